// File: rtl/fifo_pkt_reader.sv
// Read-domain packet reader: strips length headers from the FIFO and presents the
// payload as a registered valid/ready stream with start/end-of-packet marks.
//
// state     | meaning
// S_HDR     | next FIFO word is a header; zero-length headers are dropped
// S_PAYLOAD | popping payload words; rem words of the packet still in the FIFO
module fifo_pkt_reader #(
  parameter int D_SIZE = 16,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk_rd,
  input  logic              i_rstn_rd,
  input  logic              i_fifo_empty,
  input  logic [D_SIZE-1:0] i_fifo_rd_data,
  output logic              o_fifo_rd_en,
  output logic [D_SIZE-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sop,
  output logic              o_eop,
  output logic              o_hdr_err,
  output logic [CNT_W-1:0]  o_pkt_cnt
);

  localparam logic [0:0] S_HDR     = 1'b0;
  localparam logic [0:0] S_PAYLOAD = 1'b1;

  logic [0:0]       state;
  logic [LEN_W-1:0] rem;
  logic             first;
  logic [LEN_W-1:0] hdr_len;
  logic             out_free;
  logic             pop_hdr;
  logic             pop_pay;
  logic             last_word;

  assign hdr_len   = i_fifo_rd_data[LEN_W-1:0];
  assign out_free  = !o_valid || i_ready;
  assign last_word = (rem == LEN_W'(1));

  // Header pops never touch the output register, so they ignore backpressure.
  assign o_fifo_rd_en = i_rstn_rd && !i_fifo_empty &&
                        ((state == S_HDR) || ((state == S_PAYLOAD) && out_free));
  assign pop_hdr = o_fifo_rd_en && (state == S_HDR);
  assign pop_pay = o_fifo_rd_en && (state == S_PAYLOAD);

  always_ff @(posedge i_clk_rd) begin
    if (!i_rstn_rd) begin
      state <= S_HDR;
      rem   <= '0;
      first <= 1'b0;
    end else if (pop_hdr) begin
      if (hdr_len != '0) begin
        rem   <= hdr_len;
        first <= 1'b1;
        state <= S_PAYLOAD;
      end
    end else if (pop_pay) begin
      first <= 1'b0;
      rem   <= rem - LEN_W'(1);
      if (last_word) begin
        state <= S_HDR;
      end
    end
  end

  always_ff @(posedge i_clk_rd) begin
    if (!i_rstn_rd) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      o_hdr_err <= 1'b0;
      o_pkt_cnt <= '0;
    end else begin
      o_hdr_err <= pop_hdr && (hdr_len == '0);
      if (pop_pay) begin
        o_data  <= i_fifo_rd_data;
        o_valid <= 1'b1;
        o_sop   <= first;
        o_eop   <= last_word;
        if (last_word) begin
          o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_sop   <= 1'b0;
        o_eop   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: array-backed show-ahead FIFO, packet-level parser model
// and an expected-beat queue built from the packets as they are written.
module tb_fifo_pkt_reader;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        rd_en;
  logic [15:0] o_data;
  logic        o_valid;
  logic        ready;
  logic        o_sop;
  logic        o_eop;
  logic        o_hdr_err;
  logic [15:0] o_pkt_cnt;

  logic [15:0] mem [0:4095];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic        fifo_hold;

  bit          hdr_next = 1'b1;
  int          mrem = 0;
  logic        exp_err = 1'b0;
  int          model_cnt = 0;
  beat_t       exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  int idle_cnt = 0;
  int err_pulses = 0;

  bit    prev_stall = 1'b0;
  beat_t held;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr) || fifo_hold;
  assign fifo_data  = mem[rd_ptr[11:0]];

  fifo_pkt_reader #(.D_SIZE(16), .LEN_W(8), .CNT_W(16)) dut (
    .i_clk_rd      (clk),
    .i_rstn_rd     (rstn),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_rd_data(fifo_data),
    .o_fifo_rd_en  (rd_en),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (ready),
    .o_sop         (o_sop),
    .o_eop         (o_eop),
    .o_hdr_err     (o_hdr_err),
    .o_pkt_cnt     (o_pkt_cnt)
  );

  // FIFO pop and packet parser: header words set the remaining length, payload counts down.
  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        hdr_next  = 1'b1;
        mrem      = 0;
        exp_err   = 1'b0;
        model_cnt = 0;
      end else begin
        exp_err = 1'b0;
        if (rd_en) begin
          rd_ptr <= rd_ptr + 1;
          if (hdr_next) begin
            if (fifo_data[7:0] == 8'd0) exp_err = 1'b1;
            else begin
              mrem     = int'(fifo_data[7:0]);
              hdr_next = 1'b0;
            end
          end else begin
            mrem = mrem - 1;
            if (mrem == 0) begin
              hdr_next  = 1'b1;
              model_cnt = model_cnt + 1;
            end
          end
        end
      end
    end
  end

  // Negedge monitor: values seen here are the ones the next rising edge samples.
  initial begin
    bit    exp_rd;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        n_checks++;
        if (rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_en_in_reset: got %b expected 0 at %0t", rd_en, $time);
        end
        prev_stall = 1'b0;
      end else begin
        exp_rd = !fifo_empty && (hdr_next || !o_valid || ready);
        n_checks++;
        if (rd_en !== exp_rd) begin
          n_fail++;
          $display("FAIL rd_en_rule: got %b expected %b at %0t", rd_en, exp_rd, $time);
        end
        n_checks++;
        if (o_hdr_err !== exp_err) begin
          n_fail++;
          $display("FAIL hdr_err: got %b expected %b at %0t", o_hdr_err, exp_err, $time);
        end
        if (o_hdr_err === 1'b1) err_pulses++;
        n_checks++;
        if (o_pkt_cnt !== 16'(model_cnt)) begin
          n_fail++;
          $display("FAIL pkt_cnt: got %0d expected %0d at %0t", o_pkt_cnt, 16'(model_cnt), $time);
        end
        if (prev_stall) begin
          n_checks++;
          if ({o_data, o_sop, o_eop} !== {held.d, held.sop, held.eop}) begin
            n_fail++;
            $display("FAIL stall_hold: got %h/%b/%b expected %h/%b/%b at %0t",
                     o_data, o_sop, o_eop, held.d, held.sop, held.eop, $time);
          end
        end
        if (o_valid === 1'b1 && ready === 1'b1) begin
          xfer_cnt++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_beat: got %h with no beat expected at %0t", o_data, $time);
          end else begin
            e = exp_q.pop_front();
            if ({o_data, o_sop, o_eop} !== {e.d, e.sop, e.eop}) begin
              n_fail++;
              $display("FAIL beat: got %h/%b/%b expected %h/%b/%b at %0t",
                       o_data, o_sop, o_eop, e.d, e.sop, e.eop, $time);
            end
          end
        end
        if (o_valid !== 1'b1) idle_cnt++;
        prev_stall = (o_valid === 1'b1) && (ready === 1'b0);
        held.d   = o_data;
        held.sop = o_sop;
        held.eop = o_eop;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [7:0] len, input logic [7:0] upper);
    mem[wr_ptr[11:0]] = {upper, len};
    wr_ptr++;
  endtask

  task automatic push_word(input logic [15:0] d, input bit sop, input bit eop);
    beat_t b;
    mem[wr_ptr[11:0]] = d;
    wr_ptr++;
    b.d   = d;
    b.sop = sop;
    b.eop = eop;
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(input int len, input logic [7:0] upper);
    push_hdr(len[7:0], upper);
    for (int i = 0; i < len; i++) push_word(16'($urandom), i == 0, i == len - 1);
  endtask

  task automatic wait_drain(input int max, input string name);
    int c = 0;
    while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && c < max) begin
      step();
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0 || rd_ptr != wr_ptr) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d beats and %0d words left after %0d cycles, expected 0",
               name, exp_q.size(), wr_ptr - rd_ptr, c);
    end
  endtask

  task automatic check_cnt(input logic [15:0] exp, input string name);
    n_checks++;
    if (o_pkt_cnt !== exp) begin
      n_fail++;
      $display("FAIL %s_pkt_cnt: got %0d expected %0d", name, o_pkt_cnt, exp);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ready = 1'b1;
    fifo_hold = 1'b0;
    step();
    step();
    push_hdr(8'h03, 8'h00);
    push_word(16'hA1A1, 1'b1, 1'b0);
    push_word(16'hB2B2, 1'b0, 1'b0);
    push_word(16'hC3C3, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_en: got %b expected 0", rd_en);
    end
    n_checks++;
    if ({o_valid, o_sop, o_eop, o_hdr_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {o_valid, o_sop, o_eop, o_hdr_err});
    end
    n_checks++;
    if (o_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0000", o_data);
    end
    n_checks++;
    if (o_pkt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_pkt_cnt: got %0d expected 0", o_pkt_cnt);
    end
    step();
  endtask

  task automatic test_basic();
    logic [7:0] rd_pat;
    logic [7:0] v_pat;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_pat[i] = rd_en;
      v_pat[i]  = o_valid;
      step();
    end
    n_checks++;
    if (rd_pat !== 8'h0F) begin
      n_fail++; $display("FAIL basic_rd_en_pattern: got %b expected 00001111", rd_pat);
    end
    n_checks++;
    if (v_pat !== 8'h1C) begin
      n_fail++; $display("FAIL basic_valid_pattern: got %b expected 00011100", v_pat);
    end
    check_cnt(16'd1, "basic");
    wait_drain(5, "basic");
  endtask

  task automatic test_hdr_zero();
    int e0 = err_pulses;
    push_hdr(8'h00, 8'h00);
    push_hdr(8'h01, 8'h5A);
    push_word(16'hD00D, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (err_pulses - e0 != 1) begin
      n_fail++; $display("FAIL hdr_err_pulses: got %0d expected 1", err_pulses - e0);
    end
    check_cnt(16'd2, "hdr_zero");
    wait_drain(5, "hdr_zero");
  endtask

  task automatic test_stall();
    logic [6:0] pat = 7'b1011001;
    int x0 = xfer_cnt;
    int c = 0;
    push_pkt(4, 8'h33);
    while (o_valid !== 1'b1 && c < 10) begin
      step();
      c++;
    end
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_first_valid: got %b expected 1 within 10 cycles", o_valid);
    end
    for (int i = 0; i < 7; i++) begin
      ready = pat[i];
      step();
    end
    ready = 1'b1;
    wait_drain(20, "stall");
    n_checks++;
    if (xfer_cnt - x0 != 4) begin
      n_fail++; $display("FAIL stall_transfers: got %0d expected 4", xfer_cnt - x0);
    end
    check_cnt(16'd3, "stall");
  endtask

  task automatic test_underflow();
    push_hdr(8'h05, 8'hC0);
    push_word(16'h1111, 1'b1, 1'b0);
    push_word(16'h2222, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++; $display("FAIL underflow_gap_valid: got %b expected 0 (gap cycle %0d)", o_valid, i);
      end
      step();
    end
    push_word(16'h3333, 1'b0, 1'b0);
    push_word(16'h4444, 1'b0, 1'b0);
    push_word(16'h5555, 1'b0, 1'b1);
    wait_drain(20, "underflow");
    check_cnt(16'd4, "underflow");
  endtask

  task automatic test_mid_reset();
    push_hdr(8'h06, 8'h00);
    push_word(16'h6001, 1'b1, 1'b0);
    push_word(16'h6002, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    rstn = 1'b0;
    exp_q.delete();
    step();
    push_hdr(8'h02, 8'h00);
    push_word(16'hEEEE, 1'b1, 1'b0);
    push_word(16'hFFFF, 1'b0, 1'b1);
    step();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", o_valid);
    end
    check_cnt(16'd0, "mid_reset_cleared");
    n_checks++;
    if (rd_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_rd_en: got %b expected 0", rd_en);
    end
    rstn = 1'b1;
    wait_drain(20, "mid_reset");
    check_cnt(16'd1, "mid_reset");
  endtask

  task automatic test_back_to_back();
    int x0 = xfer_cnt;
    int c = 0;
    int cyc = 0;
    push_pkt(1, 8'h11);
    push_pkt(255, 8'h22);
    push_pkt(1, 8'h33);
    while (o_valid !== 1'b1 && c < 10) begin
      step();
      c++;
    end
    n_checks++;
    if (c != 2) begin
      n_fail++; $display("FAIL b2b_first_latency: got %0d cycles expected 2", c);
    end
    idle_cnt = 0;
    while (exp_q.size() != 0 && cyc < 600) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != 259) begin
      n_fail++; $display("FAIL b2b_cycles: got %0d expected 259", cyc);
    end
    n_checks++;
    if (idle_cnt != 2) begin
      n_fail++; $display("FAIL b2b_bubbles: got %0d expected 2", idle_cnt);
    end
    n_checks++;
    if (xfer_cnt - x0 != 257) begin
      n_fail++; $display("FAIL b2b_transfers: got %0d expected 257", xfer_cnt - x0);
    end
    wait_drain(5, "b2b");
    check_cnt(16'd4, "b2b");
  endtask

  task automatic test_random();
    int n_good = 0;
    int n_zero = 0;
    int e0 = err_pulses;
    int c = 0;
    int len;
    for (int p = 0; p < 20; p++) begin
      len = (p == 3) ? 0 : int'($urandom_range(0, 20));
      if (len == 0) n_zero++;
      else n_good++;
      push_pkt(len, 8'($urandom));
    end
    while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && c < 3000) begin
      ready     = ($urandom_range(0, 9) < 7);
      fifo_hold = ($urandom_range(0, 9) < 3);
      step();
      c++;
    end
    ready = 1'b1;
    fifo_hold = 1'b0;
    wait_drain(50, "random");
    step();
    step();
    check_cnt(16'(4 + n_good), "random");
    n_checks++;
    if (err_pulses - e0 != n_zero) begin
      n_fail++; $display("FAIL random_hdr_err_pulses: got %0d expected %0d", err_pulses - e0, n_zero);
    end
  endtask

  initial begin
    rstn = 1'b0;
    ready = 1'b1;
    fifo_hold = 1'b0;
    test_reset();
    test_basic();
    test_hdr_zero();
    test_stall();
    test_underflow();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
